// File: rtl/serial_packet_fifo.sv
// Packet-delimiting byte FIFO: stages each received byte until the next byte or an idle edge marks its position.
// Latency: byte N enters the FIFO on byte N+1's strobe or the next idle_timeout rise; head visible one cycle later.
// Backpressure: none upstream; pushes into a full FIFO (without a simultaneous pop) are dropped and flagged in overflow.
//
// Ports:
//   clk, reset          - system clock, asynchronous active-low reset
//   byte_in/byte_strobe - received byte and its one-cycle valid pulse
//   idle_timeout        - line-idle level; its rising edge closes the current packet
//   data_out/data_last  - show-ahead head byte and end-of-packet marker
//   data_valid/ready    - FIFO non-empty / consumer accept (pop when both high)
//   packet_count        - complete packets currently held
//   overflow/_clear     - sticky drop flag and its clear
module serial_packet_fifo #(
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_strobe,
  input  logic                  idle_timeout,
  output logic [7:0]            data_out,
  output logic                  data_last,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [DEPTH_BITS:0]   packet_count,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  localparam int                  DEPTH      = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
  localparam logic [DEPTH_BITS:0] CNT_ONE    = (DEPTH_BITS + 1)'(1);

  // Entry layout: {last, byte}
  logic [8:0]            mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic [7:0]            stage_byte;
  logic                  stage_valid;
  logic                  idle_prev;

  logic       idle_rise;
  logic       push_req;
  logic       push_last;
  logic       full;
  logic       pop;
  logic       push_ok;
  logic       drop;
  logic       pkt_inc;
  logic       pkt_dec;
  logic [8:0] head;

  always_comb begin
    idle_rise = idle_timeout & ~idle_prev;
    // A new byte always wins over a coincident idle edge: the staged byte is
    // then known not to be last, and the edge is discarded.
    push_req  = stage_valid & (byte_strobe | idle_rise);
    push_last = ~byte_strobe;
    full      = (count == FULL_COUNT);
    pop       = data_valid & data_ready;
    // At full, a same-cycle pop frees the slot the push needs.
    push_ok   = push_req & (~full | pop);
    drop      = push_req & full & ~pop;
    pkt_inc   = push_ok & push_last;
    pkt_dec   = pop & data_last;
  end

  assign data_valid = (count != '0);
  assign head       = mem[rd_ptr];
  // Memory is not cleared on reset, so mask the head while empty to keep
  // outputs at zero during and after reset.
  assign data_out   = data_valid ? head[7:0] : 8'h00;
  assign data_last  = data_valid & head[8];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {push_last, stage_byte};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stage_byte   <= '0;
      stage_valid  <= 1'b0;
      idle_prev    <= 1'b0;
      packet_count <= '0;
      overflow     <= 1'b0;
    end else begin
      idle_prev <= idle_timeout;

      if (byte_strobe) begin
        stage_byte  <= byte_in;
        stage_valid <= 1'b1;
      end else if (idle_rise) begin
        stage_valid <= 1'b0;
      end

      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;

      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      case ({pkt_inc, pkt_dec})
        2'b10:   packet_count <= packet_count + CNT_ONE;
        2'b01:   packet_count <= packet_count - CNT_ONE;
        default: packet_count <= packet_count;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)                overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_packet_fifo.sv
// Bench for serial_packet_fifo: directed scenarios plus random traffic against a queue-based reference model.
// Expected FIFO entries go into a scoreboard queue; a monitor compares the head on every accepted pop.
// Inputs change 1 ns after the rising edge; everything is sampled on the falling edge.
module tb_serial_packet_fifo;

  localparam int DEPTH_BITS = 4;
  localparam int DEPTH      = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          byte_in = 8'h00;
  logic                byte_strobe = 1'b0;
  logic                idle_timeout = 1'b0;
  logic                data_ready = 1'b0;
  logic                overflow_clear = 1'b0;
  logic [7:0]          data_out;
  logic                data_last;
  logic                data_valid;
  logic [DEPTH_BITS:0] packet_count;
  logic                overflow;

  serial_packet_fifo #(.DEPTH_BITS(DEPTH_BITS)) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_in        (byte_in),
    .byte_strobe    (byte_strobe),
    .idle_timeout   (idle_timeout),
    .data_out       (data_out),
    .data_last      (data_last),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .packet_count   (packet_count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [8:0] mq[$];      // model FIFO contents {last, byte}
  logic [8:0] exp_q[$];   // scoreboard: entries the monitor expects to see popped
  logic [7:0] m_stage;
  bit         m_stage_v;
  bit         m_prev_idle;
  int         m_pkts;
  bit         m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_stage_v   = 1'b0;
    m_prev_idle = 1'b0;
    m_pkts      = 0;
    m_ovf       = 1'b0;
  endtask

  // Effect of the coming rising edge, computed from the current inputs.
  task automatic model_step();
    bit         rise;
    bit         pop;
    bit         push;
    logic [8:0] ent;
    logic [8:0] gone;
    rise = idle_timeout && !m_prev_idle;
    pop  = (mq.size() != 0) && data_ready;
    push = 1'b0;
    ent  = '0;
    if (byte_strobe) begin
      if (m_stage_v) begin
        push = 1'b1;
        ent  = {1'b0, m_stage};
      end
      m_stage   = byte_in;
      m_stage_v = 1'b1;
    end else if (rise && m_stage_v) begin
      push      = 1'b1;
      ent       = {1'b1, m_stage};
      m_stage_v = 1'b0;
    end
    m_prev_idle = idle_timeout;
    if (pop) begin
      gone = mq.pop_front();
      if (gone[8]) m_pkts--;
    end
    if (push && mq.size() >= DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      if (push) begin
        mq.push_back(ent);
        exp_q.push_back(ent);
        if (ent[8]) m_pkts++;
      end
      if (overflow_clear) m_ovf = 1'b0;
    end
  endtask

  task automatic check_state();
    chk("data_valid", int'(data_valid), int'(mq.size() != 0));
    chk("packet_count", int'(packet_count), m_pkts);
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  // One clock cycle: entered and left 1 ns after a rising edge.
  task automatic tick(input logic [7:0] b, input logic s, input logic idl,
                      input logic rdy, input logic oc);
    byte_in        = b;
    byte_strobe    = s;
    idle_timeout   = idl;
    data_ready     = rdy;
    overflow_clear = oc;
    @(negedge clk);
    check_state();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(8'h00, 1'b0, idle_timeout, 1'b1, 1'b0);
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && data_valid === 1'b1 && data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: actual=0x%0h expected=none", {data_last, data_out});
      end else begin
        chk("pop_head", int'({data_last, data_out}), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit idl;
    model_reset();

    // Power-on reset: outputs must be zero while reset is held.
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_last", int'(data_last), 0);
    chk("rst_out", int'(data_out), 0);
    chk("rst_pkt", int'(packet_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Three bytes then idle edge: one packet, head 0x11 visible right after the edge.
    tick(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1_pre_edge_pkt", int'(packet_count), 0);
    tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s1_valid", int'(data_valid), 1);
    chk("s1_head", int'(data_out), 8'h11);
    chk("s1_head_last", int'(data_last), 0);
    chk("s1_pkt", int'(packet_count), 1);
    tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(4);
    chk("s1_drained_pkt", int'(packet_count), 0);

    // Idle edge with nothing staged does nothing.
    tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s2_valid", int'(data_valid), 0);
    chk("s2_pkt", int'(packet_count), 0);
    tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 18 bytes with no consumer: 16 stored, 17 and 18 dropped.
    for (int i = 1; i <= 18; i++) tick(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s3_ovf", int'(overflow), 1);
    chk("s3_pkt", int'(packet_count), 0);
    chk("s3_head", int'(data_out), 8'h01);
    tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s3_ovf_cleared", int'(overflow), 0);

    // Full FIFO: push with a simultaneous pop is accepted.
    tick(8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(8'h51, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s4_ovf", int'(overflow), 0);
    chk("s4_head", int'(data_out), 8'h02);
    tick(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("s4_ovf_after_edge", int'(overflow), 0);
    chk("s4_pkt", int'(packet_count), 1);
    tick(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(20);
    chk("s4_empty", int'(data_valid), 0);

    // Strobe and idle edge coincide: strobe wins.
    tick(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(8'hBB, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s5_head", int'(data_out), 8'hAA);
    chk("s5_last", int'(data_last), 0);
    chk("s5_pkt", int'(packet_count), 0);
    tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s5_pkt_bb", int'(packet_count), 1);
    drain(4);

    // Random traffic: first half mostly stalled to provoke overflow.
    idl = idle_timeout;
    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      bit         s;
      bit         rdy;
      bit         oc;
      b   = 8'($urandom);
      s   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0) idl = !idl;
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      oc  = ($urandom_range(0, 15) == 0);
      tick(b, s, idl, rdy, oc);
    end
    tick(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    drain(20);
    chk("rand_scoreboard_empty", exp_q.size(), 0);
    tick(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-packet: 3 entries plus a staged byte are discarded.
    for (int i = 0; i < 4; i++) tick(8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s6_pre_valid", int'(data_valid), 1);
    chk("s6_pre_head", int'(data_out), 8'hC0);
    #2 reset = 1'b0;
    #1;
    chk("s6_rst_valid", int'(data_valid), 0);
    chk("s6_rst_last", int'(data_last), 0);
    chk("s6_rst_out", int'(data_out), 0);
    chk("s6_rst_pkt", int'(packet_count), 0);
    chk("s6_rst_ovf", int'(overflow), 0);
    model_reset();
    byte_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s6_after_valid", int'(data_valid), 0);
    chk("s6_after_pkt", int'(packet_count), 0);
    tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
